conv33_weight_stream: RTL
=========================

# conv33_weight_stream

Transmit side of the conv33 serial weight-load interface. Stores 3x3 kernels for up to NUM_KERNELS output channels in a local RAM. On request, it streams the 9 taps of one kernel serially, framed by `start`, into the conv33 weight loader. It then waits for the loader's one-cycle `weight_load` completion pulse before reporting `done`.

## Interface
- `DATA_WIDTH`, 8: weight width in bits.
- `NUM_KERNELS`, 16: number of stored kernels; must be ≥ 2.
- `ACK_TIMEOUT`, 15: maximum cycles spent in WAIT_ACK; only used when the timeout feature is compiled in.
- Derived localparams:
  - `KIDX_W` = $clog2(NUM_KERNELS)
  - `ADDR_W` = $clog2(NUM_KERNELS*9)
- Ports:
  - `clk`  in  1  sole clock; all logic on posedge.
  - `rst`  in  1  synchronous, active-high reset.
  - `wr_en`  in  1  RAM write strobe.
  - `wr_addr`  in  ADDR_W  RAM address = kidx*9 + tap, tap 0..8 in row-major order.
  - `wr_data`  in  DATA_WIDTH  write data.
  - `req`  in  1  request to stream one kernel; level-sampled in IDLE.
  - `req_kidx`  in  KIDX_W  index of the kernel to stream.
  - `busy`  out  1  high whenever the state is not IDLE.
  - `start`  out  1  frame strobe to the loader; high for exactly 9 consecutive cycles per transfer.
  - `data_out`  out  DATA_WIDTH  tap value; valid whenever `start` is high.
  - `weight_load`  in  1  completion pulse from the loader.
  - `done`  out  1  one-cycle pulse: transfer acknowledged.
  - `err`  out  1  one-cycle pulse: acknowledge timeout.

## Operation
- States:
  - IDLE → SEND on `req` with `req_kidx` < NUM_KERNELS.
  - SEND → WAIT_ACK after beat 8.
  - WAIT_ACK → IDLE on `weight_load`, or on timeout.
- Requests:
  - `req` with `req_kidx` ≥ NUM_KERNELS: ignored, no state change, no `err`.
  - `req` outside IDLE: ignored; there is no queueing.
  - `req_kidx` is latched on acceptance; later changes have no effect.
- SEND:
  - Beat counter runs 0..8.
  - `data_out` = RAM[kidx*9 + beat].
  - `start` = 1.
- Writes:
  - `wr_en` while `busy`=1: ignored; the RAM is frozen during a transfer.
  - `wr_en` with `wr_addr` ≥ NUM_KERNELS*9: ignored.
- WAIT_ACK:
  - `start` = 0.
  - On `weight_load`=1: pulse `done`, go to IDLE.
- `weight_load` seen outside WAIT_ACK (IDLE or SEND): ignored.
- Arithmetic:
  - Address = kidx*9 + beat, computed in ADDR_W bits; cannot overflow for legal kidx.
  - Beat counter is 4 bits wide.

## Timing
- Reset values:
  - State = IDLE; `busy`, `start`, `done`, `err` = 0.
  - `data_out` = 0; beat counter and timeout counter = 0.
  - RAM contents are not reset.
- Request acceptance: `req` sampled high at edge N (in IDLE) gives the following from edge N:
  - `busy`=1, `start`=1, `data_out`=tap0.
- Beats:
  - tap k is driven from edge N+k, for k = 0..8.
  - The loader samples tap k at edge N+k+1.
- End of SEND: at edge N+9, `start` falls and `data_out` returns to 0.
- Acknowledge: the loader's `weight_load` is expected high in the cycle after edge N+9.
  - If `weight_load` is sampled at edge M, `done`=1 during cycle M..M+1 and `busy` falls at M.
- Minimum transfer time is 11 cycles from request to `done`. The next `req` can be accepted at edge M+1.
- RAM write: a write at edge W is visible to a transfer accepted at edge W or later.
- Reset mid-transfer: at the reset edge, `start` drops immediately and all outputs return to reset values. No `done` or `err` is issued.

## Configuration
- Macro: `CONV33_WEIGHT_STREAM_TIMEOUT_EN`.
- Defined:
  - The timeout counter clears on entry to WAIT_ACK and increments each cycle in WAIT_ACK.
  - When it reaches ACK_TIMEOUT with no `weight_load`, `err` pulses for 1 cycle and the state returns to IDLE. No `done` is issued.
  - If `weight_load` arrives in the same cycle as the timeout, it wins: `done` is issued, not `err`.
- Undefined: WAIT_ACK waits indefinitely. The `err` port remains present and is tied to 0. No counter logic is generated.

## Structure
- Shared package `conv33_pkg` holds:
  - `KERNEL_TAPS` = 9.
  - The default DATA_WIDTH.
  - The state enum (IDLE, SEND, WAIT_ACK).
  - Because the same package is used by the loader, both ends agree on the tap count.
- Sub-module `conv33_weight_ram`:
  - NUM_KERNELS*9 × DATA_WIDTH.
  - Synchronous write, asynchronous read.
  - Write-enable gating on `busy` is done in the parent.

## Test plan
- Load kernel 3 with values 0x10..0x18, `req`=1 with kidx=3: `start` high for 9 cycles, `data_out` = 0x10, 0x11, … 0x18 in order. Return `weight_load` 1 cycle after `start` falls: `done` pulses exactly once, 11 cycles after the request.
- Pair the block with the conv33 weight loader: after `done`, the loader's parallel outputs weight_0..8 equal 0x10..0x18.
- `req` with kidx = NUM_KERNELS: no `busy`, no `start`. Also, `req` during SEND: ignored, and the transfer completes unchanged.
- `wr_en` to kidx 3 tap 4 with value 0xFF during SEND: beat 4 still sends 0x14. A new request after `done` sends 0xFF at beat 4.
- `rst` asserted at beat 5: `start`, `busy` and `data_out` all read 0 the next cycle, with no `done`.
- With the macro defined, withhold `weight_load`: `err` pulses ACK_TIMEOUT=15 cycles after `start` falls, then a new request is accepted. With the macro undefined, `busy` stays high indefinitely.

Source files
------------

// File: rtl/conv33_pkg.sv
// rtl/conv33_pkg.sv - shared conv33 constants and weight-stream state encoding
package conv33_pkg;

    // Taps per 3x3 kernel. The loader imports this same package, so both ends agree on it.
    localparam int KERNEL_TAPS        = 9;
    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

endpackage

// File: rtl/conv33_weight_ram.sv
// rtl/conv33_weight_ram.sv - kernel weight store, synchronous write, asynchronous read
//
// Ports:
//   clk      in   write clock
//   wr_en    in   write strobe (already qualified by the parent)
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address
//   rd_data  out  combinational read data
module conv33_weight_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 144,
    parameter int ADDR_W     = 8
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/conv33_weight_stream.sv
// rtl/conv33_weight_stream.sv - streams one stored 3x3 kernel serially to the conv33 weight loader
//
// Optional feature macro: CONV33_WEIGHT_STREAM_TIMEOUT_EN (acknowledge timeout raising err).
//
// Ports:
//   clk          in   clock, posedge
//   rst          in   synchronous active-high reset
//   wr_en        in   RAM write strobe (ignored while busy or out of range)
//   wr_addr      in   RAM address = kidx*9 + tap
//   wr_data      in   RAM write data
//   req          in   stream request, sampled in IDLE
//   req_kidx     in   kernel index for the request
//   busy         out  state is not IDLE
//   start        out  high for the 9 beats of a transfer
//   data_out     out  tap value while start is high, else 0
//   weight_load  in   loader completion pulse
//   done         out  one-cycle acknowledge pulse
//   err          out  one-cycle acknowledge-timeout pulse
module conv33_weight_stream
    import conv33_pkg::*;
#(
    parameter int  DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int  NUM_KERNELS = 16,
    parameter int  ACK_TIMEOUT = 15,
    localparam int KIDX_W      = $clog2(NUM_KERNELS),
    localparam int ADDR_W      = $clog2(NUM_KERNELS*KERNEL_TAPS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  req,
    input  logic [KIDX_W-1:0]     req_kidx,
    output logic                  busy,
    output logic                  start,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  weight_load,
    output logic                  done,
    output logic                  err
);

    state_t              r_state, w_state_nxt;
    logic [3:0]          r_beat, w_beat_nxt;
    logic [KIDX_W-1:0]   r_kidx, w_kidx_nxt;
    logic                r_done, w_done_nxt;
    logic                w_wr_ok;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic [DATA_WIDTH-1:0] w_rd_data;

`ifdef CONV33_WEIGHT_STREAM_TIMEOUT_EN
    localparam int TCNT_W = $clog2(ACK_TIMEOUT + 1);
    logic [TCNT_W-1:0]   r_tcnt, w_tcnt_nxt;
    logic                r_err, w_err_nxt;
`endif

    // The RAM is frozen during a transfer; out-of-range addresses are dropped.
    assign w_wr_ok   = wr_en && (r_state == IDLE) && (int'(wr_addr) < NUM_KERNELS*KERNEL_TAPS);
    assign w_rd_addr = ADDR_W'(r_kidx) * ADDR_W'(KERNEL_TAPS) + ADDR_W'(r_beat);

    conv33_weight_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (NUM_KERNELS*KERNEL_TAPS),
        .ADDR_W     (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (w_wr_ok),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (w_rd_addr),
        .rd_data (w_rd_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_kidx_nxt  = r_kidx;
        w_done_nxt  = 1'b0;
`ifdef CONV33_WEIGHT_STREAM_TIMEOUT_EN
        w_tcnt_nxt  = r_tcnt;
        w_err_nxt   = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (req && (int'(req_kidx) < NUM_KERNELS)) begin
                    w_state_nxt = SEND;
                    w_beat_nxt  = 4'd0;
                    w_kidx_nxt  = req_kidx;
                end
            end
            SEND: begin
                if (r_beat == 4'(KERNEL_TAPS - 1)) begin
                    w_state_nxt = WAIT_ACK;
                    w_beat_nxt  = 4'd0;
`ifdef CONV33_WEIGHT_STREAM_TIMEOUT_EN
                    w_tcnt_nxt  = '0;
`endif
                end else begin
                    w_beat_nxt = r_beat + 4'd1;
                end
            end
            WAIT_ACK: begin
                // An acknowledge in the timeout cycle takes priority over err.
                if (weight_load) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
`ifdef CONV33_WEIGHT_STREAM_TIMEOUT_EN
                else if (r_tcnt == TCNT_W'(ACK_TIMEOUT - 1)) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_tcnt_nxt = r_tcnt + 1'b1;
                end
`endif
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_beat  <= 4'd0;
            r_kidx  <= '0;
            r_done  <= 1'b0;
`ifdef CONV33_WEIGHT_STREAM_TIMEOUT_EN
            r_tcnt  <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            r_kidx  <= w_kidx_nxt;
            r_done  <= w_done_nxt;
`ifdef CONV33_WEIGHT_STREAM_TIMEOUT_EN
            r_tcnt  <= w_tcnt_nxt;
            r_err   <= w_err_nxt;
`endif
        end
    end

    // data_out reads the RAM combinationally so a write landing on the
    // acceptance edge is already visible at beat 0.
    assign busy     = (r_state != IDLE);
    assign start    = (r_state == SEND);
    assign data_out = start ? w_rd_data : '0;
    assign done     = r_done;

`ifdef CONV33_WEIGHT_STREAM_TIMEOUT_EN
    assign err = r_err;
`else
    // No timeout in this build: err is constant 0 (the condition is always false).
    assign err = (ACK_TIMEOUT < 0);
`endif

endmodule
